// File: rtl/oled_req_arbiter.sv
// ---------------------------------------------------------------------------
// oled_req_arbiter
//
// Shares one OLED draw engine among NREQ requesters. After reset it runs the
// engine's register-init command, then the GRAM-clear command, and only then
// raises ready. From that point it grants the engine round-robin, one command
// at a time. Each command runs until eng_done, or until TIMEOUT_CYC cycles
// have passed, whichever comes first.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   req             per-requester request level, held until ack
//   req_cmd         4-bit command per requester (slice i at [4*i +: 4])
//   req_char        5-bit character address per requester
//   req_x           8-bit column per requester
//   req_y           3-bit page per requester
//   gnt             one-hot grant, high while that requester's command runs
//   ack             one-cycle completion pulse to the granted requester
//   ready           high once the init and clear commands have finished
//   timeout_err     sticky flag, set by any engine timeout
//   eng_en          engine enable
//   eng_cmd/char/x/y engine operands, frozen while a command runs
//   eng_done        engine completion
// ---------------------------------------------------------------------------
module oled_req_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter logic [3:0]  CMD_INIT    = 4'd1,
   parameter logic [3:0]  CMD_CLS     = 4'd2,
   parameter int unsigned TIMEOUT_CYC = 1048576
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_cmd,
   input  logic [5*NREQ-1:0] req_char,
   input  logic [8*NREQ-1:0] req_x,
   input  logic [3*NREQ-1:0] req_y,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic              ready,
   output logic              timeout_err,
   output logic              eng_en,
   output logic [3:0]        eng_cmd,
   output logic [4:0]        eng_char,
   output logic [7:0]        eng_x,
   output logic [2:0]        eng_y,
   input  logic              eng_done
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_GAP1,
      S_CLS,
      S_GAP2,
      S_IDLE,
      S_BUSY,
      S_REL
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   ptr_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] ack_q;
   logic            ready_q;
   logic            terr_q;
   logic            en_q;
   logic [3:0]      cmd_q;
   logic [4:0]      char_q;
   logic [7:0]      x_q;
   logic [2:0]      y_q;

   // Per-requester operand views of the packed input buses.
   logic [3:0] cmd_a  [NREQ];
   logic [4:0] char_a [NREQ];
   logic [7:0] x_a    [NREQ];
   logic [2:0] y_a    [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign cmd_a[gi]  = req_cmd[4*gi +: 4];
      assign char_a[gi] = req_char[5*gi +: 5];
      assign x_a[gi]    = req_x[8*gi +: 8];
      assign y_a[gi]    = req_y[3*gi +: 3];
   end

   // Round-robin pick: first set request scanning ptr+1, ptr+2, ... mod NREQ.
   // sum is one bit wider than the pointer so ptr+k never overflows before
   // the single modulo subtraction.
   logic          sel_vld;
   logic [PW-1:0] sel_idx;

   always_comb begin
      logic [PW:0] sum;
      sum     = '0;
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         if (!sel_vld && req[sum[PW-1:0]]) begin
            sel_vld = 1'b1;
            sel_idx = sum[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         ptr_q   <= PW'(NREQ - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         ready_q <= 1'b0;
         terr_q  <= 1'b0;
         en_q    <= 1'b0;
         cmd_q   <= '0;
         char_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            S_INIT: begin
               // done has priority over a coincident timeout
               if (eng_done || cnt_q == CNT_LAST) begin
                  en_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_GAP1;
                  if (!eng_done) begin
                     terr_q <= 1'b1;
                  end
               end else begin
                  en_q  <= 1'b1;
                  cmd_q <= CMD_INIT;
                  if (en_q) begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end

            // Raising en here keeps it low for exactly the one gap cycle.
            S_GAP1: begin
               en_q    <= 1'b1;
               cmd_q   <= CMD_CLS;
               cnt_q   <= '0;
               state_q <= S_CLS;
            end

            S_CLS: begin
               if (eng_done || cnt_q == CNT_LAST) begin
                  en_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_GAP2;
                  if (!eng_done) begin
                     terr_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_GAP2: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end

            S_IDLE: begin
               if (sel_vld) begin
                  gnt_q   <= NREQ'(1) << sel_idx;
                  en_q    <= 1'b1;
                  cmd_q   <= cmd_a[sel_idx];
                  char_q  <= char_a[sel_idx];
                  x_q     <= x_a[sel_idx];
                  y_q     <= y_a[sel_idx];
                  ptr_q   <= sel_idx;
                  cnt_q   <= '0;
                  state_q <= S_BUSY;
               end
            end

            S_BUSY: begin
               if (eng_done || cnt_q == CNT_LAST) begin
                  en_q    <= 1'b0;
                  gnt_q   <= '0;
                  ack_q   <= gnt_q;
                  state_q <= S_REL;
                  if (!eng_done) begin
                     terr_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_REL: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_INIT;
            end
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign ack         = ack_q;
   assign ready       = ready_q;
   assign timeout_err = terr_q;
   assign eng_en      = en_q;
   assign eng_cmd     = cmd_q;
   assign eng_char    = char_q;
   assign eng_x       = x_q;
   assign eng_y       = y_q;

endmodule

// File: tb/tb_oled_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oled_req_arbiter
//
// Scoreboard bench for oled_req_arbiter. Stimulus pushes the expected init
// commands, grants and acks into queues. A monitor pops and compares them
// whenever the DUT shows an en rise (before ready), a grant rise, or an ack.
// A simple engine model returns done 20 cycles after each en rise, unless it
// is told to hang.
// ---------------------------------------------------------------------------
module tb_oled_req_arbiter;

   localparam int         LAT = 20;
   localparam logic [3:0] CI  = 4'hA;
   localparam logic [3:0] CC  = 4'h5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_cmd;
   logic [19:0] req_char;
   logic [31:0] req_x;
   logic [11:0] req_y;
   logic [3:0]  gnt, ack;
   logic        ready, timeout_err, eng_en;
   logic [3:0]  eng_cmd;
   logic [4:0]  eng_char;
   logic [7:0]  eng_x;
   logic [2:0]  eng_y;
   logic        eng_done;
   logic        hang;

   oled_req_arbiter #(
      .NREQ(4),
      .CMD_INIT(CI),
      .CMD_CLS(CC),
      .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .req_cmd(req_cmd),
      .req_char(req_char),
      .req_x(req_x),
      .req_y(req_y),
      .gnt(gnt),
      .ack(ack),
      .ready(ready),
      .timeout_err(timeout_err),
      .eng_en(eng_en),
      .eng_cmd(eng_cmd),
      .eng_char(eng_char),
      .eng_x(eng_x),
      .eng_y(eng_y),
      .eng_done(eng_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gnt;
      logic [3:0] cmd;
      logic [4:0] chr;
      logic [7:0] x;
      logic [2:0] y;
      int         exp_cyc;   // -1: grant cycle not checked
   } gexp_t;

   typedef struct {
      logic [3:0] ack;
      int         lat;       // cycles from grant to ack
      logic       terr;
      logic [7:0] x;         // eng_x must still hold the granted operand
      int         spacing;   // 0: spacing from previous ack not checked
   } aexp_t;

   typedef struct {
      logic [3:0] cmd;
      int         gap;       // 0: gap from previous en fall not checked
   } iexp_t;

   gexp_t gq[$];
   aexp_t aq[$];
   iexp_t iq[$];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Engine model: done is high in the 20th cycle after the en-rise cycle.
   initial begin
      int ecnt;
      ecnt     = 0;
      eng_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (eng_en) begin
            eng_done = (!hang && ecnt == LAT);
            ecnt++;
         end else begin
            ecnt     = 0;
            eng_done = 1'b0;
         end
      end
   end

   // Monitor
   initial begin
      logic [3:0] p_gnt, p_ack;
      logic       p_en, p_ready;
      int         fall_cyc, grant_cyc, last_ack_cyc;
      gexp_t      ge;
      aexp_t      ae;
      iexp_t      ie;
      p_gnt = '0; p_ack = '0; p_en = 1'b0; p_ready = 1'b0;
      fall_cyc = 0; grant_cyc = 0; last_ack_cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (eng_en && !p_en && !ready) begin
            if (iq.size() == 0) begin
               chk("init_unexpected_en", 32'(eng_en), 32'd0);
            end else begin
               ie = iq.pop_front();
               chk("init_cmd", 32'(eng_cmd), 32'(ie.cmd));
               chk("init_operands", 32'({eng_char, eng_x, eng_y}), 32'd0);
               if (ie.gap > 0) chk("init_en_gap", 32'(cyc - fall_cyc), 32'(ie.gap));
            end
         end
         if (!eng_en && p_en) fall_cyc = cyc;
         if (ready && !p_ready) chk("ready_after_en_drop", 32'(cyc - fall_cyc), 32'd1);
         if (gnt != 0 && p_gnt == 0) begin
            grant_cyc = cyc;
            if (gq.size() == 0) begin
               chk("grant_unexpected", 32'(gnt), 32'd0);
            end else begin
               ge = gq.pop_front();
               chk("grant_onehot", 32'(gnt), 32'(ge.gnt));
               chk("grant_en", 32'(eng_en), 32'd1);
               chk("grant_operands", 32'({eng_cmd, eng_char, eng_x, eng_y}),
                   32'({ge.cmd, ge.chr, ge.x, ge.y}));
               if (ge.exp_cyc >= 0) chk("grant_latency", 32'(cyc), 32'(ge.exp_cyc));
            end
         end
         if (p_ack != 0) chk("ack_single_cycle", 32'(ack), 32'd0);
         else if (ack != 0) begin
            if (aq.size() == 0) begin
               chk("ack_unexpected", 32'(ack), 32'd0);
            end else begin
               ae = aq.pop_front();
               chk("ack_vector", 32'(ack), 32'(ae.ack));
               chk("ack_latency", 32'(cyc - grant_cyc), 32'(ae.lat));
               chk("ack_timeout_err", 32'(timeout_err), 32'(ae.terr));
               chk("ack_en_gnt_low", 32'({eng_en, gnt}), 32'd0);
               chk("ack_operand_frozen", 32'(eng_x), 32'(ae.x));
               if (ae.spacing > 0) chk("ack_spacing", 32'(cyc - last_ack_cyc), 32'(ae.spacing));
            end
            last_ack_cyc = cyc;
         end
         p_gnt = gnt; p_ack = ack; p_en = eng_en; p_ready = ready;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
      chk({tag, "_eng_en"}, 32'(eng_en), 32'd0);
      chk({tag, "_eng_operands"}, 32'({eng_cmd, eng_char, eng_x, eng_y}), 32'd0);
   endtask

   task automatic set_slice(input int i, input logic [3:0] c, input logic [4:0] ch,
                            input logic [7:0] x, input logic [2:0] y);
      req_cmd[i*4 +: 4]  = c;
      req_char[i*5 +: 5] = ch;
      req_x[i*8 +: 8]    = x;
      req_y[i*3 +: 3]    = y;
   endtask

   task automatic push_grant(input int i, input int expc);
      gexp_t e;
      e.gnt = 4'(1 << i);
      e.cmd = req_cmd[i*4 +: 4];
      e.chr = req_char[i*5 +: 5];
      e.x   = req_x[i*8 +: 8];
      e.y   = req_y[i*3 +: 3];
      e.exp_cyc = expc;
      gq.push_back(e);
   endtask

   task automatic push_ack(input int i, input int lat, input logic terr, input int spc);
      aexp_t e;
      e.ack = 4'(1 << i);
      e.lat = lat;
      e.terr = terr;
      e.x = req_x[i*8 +: 8];
      e.spacing = spc;
      aq.push_back(e);
   endtask

   task automatic push_init();
      iexp_t e;
      e.cmd = CI; e.gap = 0; iq.push_back(e);
      e.cmd = CC; e.gap = 1; iq.push_back(e);
   endtask

   task automatic wait_ack(input logic [3:0] mask, output logic [3:0] seen);
      logic got;
      got  = 1'b0;
      seen = '0;
      for (int k = 0; k < 200 && !got; k++) begin
         tick(1);
         if ((ack & mask) != 0) begin
            got  = 1'b1;
            seen = ack;
         end
      end
      chk("ack_within_bound", 32'(got), 32'd1);
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 200 && !ready; k++) tick(1);
      chk("ready_within_bound", 32'(ready), 32'd1);
   endtask

   task automatic single(input int i, input logic [3:0] c, input logic [4:0] ch,
                         input logic [7:0] x, input logic [2:0] y,
                         input int lat, input logic terr);
      logic [3:0] seen;
      set_slice(i, c, ch, x, y);
      push_grant(i, cyc + 1);
      push_ack(i, lat, terr, 0);
      req[i] = 1'b1;
      wait_ack(4'(1 << i), seen);
      req[i] = 1'b0;
      tick(2);
   endtask

   initial begin
      logic [3:0] seen;
      rst_n = 1'b0; hang = 1'b0; req = '0;
      req_cmd = '0; req_char = '0; req_x = '0; req_y = '0;

      // Reset values, then the init / clear sequence
      tick(3);
      check_reset("reset");
      push_init();
      rst_n = 1'b1;
      wait_ready();
      tick(3);

      // Single request from requester 2, then 3 (leaves ptr at 3)
      single(2, 4'd3, 5'd5, 8'd96, 3'd0, LAT + 1, 1'b0);
      single(3, 4'hC, 5'd17, 8'd127, 3'd7, LAT + 1, 1'b0);

      // All four requesting: order 0,1,2,3, acks LAT+3 apart
      set_slice(0, 4'd6, 5'd1, 8'd0, 3'd1);
      set_slice(1, 4'd7, 5'd2, 8'd10, 3'd2);
      set_slice(2, 4'd8, 5'd3, 8'd20, 3'd3);
      set_slice(3, 4'd9, 5'd31, 8'd30, 3'd4);
      for (int i = 0; i < 4; i++) begin
         push_grant(i, (i == 0) ? cyc + 1 : -1);
         push_ack(i, LAT + 1, 1'b0, (i == 0) ? 0 : LAT + 3);
      end
      req = 4'hF;
      for (int n = 0; n < 4; n++) begin
         wait_ack(4'hF, seen);
         req = req & ~seen;
      end
      tick(2);

      // ptr=1, then 0 and 1 together: 0 wins, then 1
      single(1, 4'd2, 5'd9, 8'd64, 3'd5, LAT + 1, 1'b0);
      push_grant(0, cyc + 1);
      push_ack(0, LAT + 1, 1'b0, 0);
      push_grant(1, -1);
      push_ack(1, LAT + 1, 1'b0, LAT + 3);
      req = 4'b0011;
      for (int n = 0; n < 2; n++) begin
         wait_ack(4'b0011, seen);
         req = req & ~seen;
      end
      tick(2);

      // Engine hangs: abort after 64 cycles; a request raised and dropped
      // meanwhile is never granted; operand changes while granted are ignored
      hang = 1'b1;
      set_slice(0, 4'd11, 5'd20, 8'd50, 3'd6);
      push_grant(0, cyc + 1);
      push_ack(0, 64, 1'b1, 0);
      req = 4'b0001;
      tick(3);
      req[3] = 1'b1;
      req_x[7:0] = 8'd200;
      tick(10);
      req[3] = 1'b0;
      wait_ack(4'b0001, seen);
      req = '0;
      hang = 1'b0;
      tick(2);

      // Next request still served; dropping req while granted changes nothing
      set_slice(2, 4'd13, 5'd7, 8'd33, 3'd2);
      push_grant(2, cyc + 1);
      push_ack(2, LAT + 1, 1'b1, 0);
      req[2] = 1'b1;
      tick(5);
      req[2] = 1'b0;
      wait_ack(4'b0100, seen);
      tick(2);

      // Asynchronous reset in the middle of a command
      set_slice(0, 4'd1, 5'd4, 8'd44, 3'd4);
      push_grant(0, cyc + 1);
      req = 4'b0001;
      tick(8);
      req = '0;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset");
      tick(2);
      push_init();
      rst_n = 1'b1;
      tick(30);
      chk("ready_low_during_rerun", 32'(ready), 32'd0);
      wait_ready();
      tick(3);

      // Pointer is back at NREQ-1: 1 beats 3
      set_slice(1, 4'd14, 5'd30, 8'd100, 3'd1);
      set_slice(3, 4'd15, 5'd29, 8'd120, 3'd0);
      push_grant(1, cyc + 1);
      push_ack(1, LAT + 1, 1'b0, 0);
      push_grant(3, -1);
      push_ack(3, LAT + 1, 1'b0, LAT + 3);
      req = 4'b1010;
      for (int n = 0; n < 2; n++) begin
         wait_ack(4'b1010, seen);
         req = req & ~seen;
      end
      tick(5);

      chk("grant_queue_drained", 32'(gq.size()), 32'd0);
      chk("ack_queue_drained", 32'(aq.size()), 32'd0);
      chk("init_queue_drained", 32'(iq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
